// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants and types for the rv32i instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Canonical rv32i NOP (addi x0, x0, 0), driven whenever decode has nothing valid.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO of {pc, inst} with clear and count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int                   c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0]    c_full   = (c_addr_w + 1)'(DEPTH);

    fetch_entry_t        r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wptr;
    logic [c_addr_w-1:0] r_rptr;
    logic [c_addr_w:0]   r_count;
    logic                w_rd;
    logic                w_wr;

    assign w_rd = i_pop & (r_count != '0);
    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign w_wr = i_push & ((r_count != c_full) | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (c_addr_w + 1)'(w_wr) - (c_addr_w + 1)'(w_rd);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : rv32i fetch stage: PC generation, imem req/gnt/rvalid issue,
//               prefetch buffering and redirect flush. Optional macro
//               FETCH_MISALIGN_EXC_EN adds misaligned-redirect halt + flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] fet_inst_o,
    output logic [31:0] fet_pc_o,
    output logic        fet_valid_o,
    input  logic        fet_stall_i,
    input  logic        fet_redir_i,
    input  logic [31:0] fet_redir_pc_i
`ifdef FETCH_MISALIGN_EXC_EN
    ,
    output logic        fet_misalign_o
`endif
);

    localparam int                 c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    logic [31:0]        r_pc;
    logic [31:0]        r_push_pc;
    logic [c_cnt_w-1:0] r_outst;
    logic [c_cnt_w-1:0] r_drop;

    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_outst_next;
    logic [c_cnt_w:0]   w_inflight;
    logic [31:0]        w_redir_tgt;
    logic               w_halt;
    logic               w_grant;
    logic               w_drop_hit;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_valid;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;

`ifdef FETCH_MISALIGN_EXC_EN
    logic r_misalign;

    // Misaligned target latches the flag and stops issue until an aligned redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (fet_redir_i) begin
            r_misalign <= |fet_redir_pc_i[1:0];
        end
    end

    assign w_halt         = r_misalign;
    assign fet_misalign_o = r_misalign;
`else
    assign w_halt = 1'b0;
`endif

    assign w_redir_tgt  = word_align(fet_redir_pc_i);
    assign w_inflight   = {1'b0, w_count} + {1'b0, r_outst};
    assign imem_req_o   = !rst_i && (w_inflight < c_depth) && !w_halt;
    assign imem_addr_o  = word_align(r_pc);
    assign w_grant      = imem_req_o & imem_gnt_i;

    assign w_outst_next = r_outst + c_cnt_w'(w_grant) - c_cnt_w'(imem_rvalid_i);
    assign w_drop_hit   = imem_rvalid_i & (r_drop != '0);
    assign w_push       = imem_rvalid_i & !w_drop_hit & !fet_redir_i;
    assign w_pop        = w_fifo_valid & !fet_stall_i & !fet_redir_i;
    assign w_push_entry = '{pc: r_push_pc, inst: imem_rdata_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_push_pc <= RESET_PC;
            r_outst   <= '0;
            r_drop    <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (fet_redir_i) begin
                // Everything still in flight after this cycle belongs to the old stream.
                r_pc      <= w_redir_tgt;
                r_push_pc <= w_redir_tgt;
                r_drop    <= w_outst_next;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_push_pc <= r_push_pc + 32'd4;
                end
                if (w_drop_hit) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (fet_redir_i),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    assign fet_valid_o = w_fifo_valid;
    assign fet_inst_o  = w_fifo_valid ? w_head.inst : INST_NOP;
    assign fet_pc_o    = w_fifo_valid ? w_head.pc   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: vector table, directed
//               redirect corner cases and randomized traffic vs. a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] fet_inst_o;
    logic [31:0] fet_pc_o;
    logic        fet_valid_o;
    logic        fet_stall_i = 1'b0;
    logic        fet_redir_i = 1'b0;
    logic [31:0] fet_redir_pc_i = '0;
`ifdef FETCH_MISALIGN_EXC_EN
    logic        fet_misalign_o;
`endif

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .fet_inst_o     (fet_inst_o),
        .fet_pc_o       (fet_pc_o),
        .fet_valid_o    (fet_valid_o),
        .fet_stall_i    (fet_stall_i),
        .fet_redir_i    (fet_redir_i),
        .fet_redir_pc_i (fet_redir_pc_i)
`ifdef FETCH_MISALIGN_EXC_EN
        ,
        .fet_misalign_o (fet_misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Memory: in-order responses, each tagged with the fetch stream it belongs to.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        bit          stall;
        bit          ev;
        logic [31:0] epc;
        bit          ereq;
        logic [31:0] eaddr;
    } vec_t;

    mreq_t       mq[$];
    int          cyc, outst, occ, epoch, pops;
    logic [31:0] exp_pc, exp_req_addr;
    bit          halt;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic        s_valid, s_req, s_mis;
    logic [31:0] s_pc, s_inst, s_addr;
    vec_t        tbl[21];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; fet_stall_i = 1'b0; imem_gnt_i = 1'b0; fet_redir_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; fet_redir_pc_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", fet_valid_o, 0);
        chk("rst_inst", fet_inst_o, INST_NOP);
        chk("rst_pc", fet_pc_o, 0);
`ifdef FETCH_MISALIGN_EXC_EN
        chk("rst_misalign", fet_misalign_o, 0);
`endif
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mq.delete();
        outst = 0; occ = 0; epoch = 0; cyc = 0; halt = 0;
        exp_pc = 32'h0; exp_req_addr = 32'h0;
    endtask

    // One clock cycle: drive, check against the stream model at negedge, then advance model.
    task automatic tick(input bit stall, input bit gnt, input bit redir,
                        input logic [31:0] rpc, input int lat);
        bit    rv, grant, pop, fresh;
        int    d;
        mreq_t m;
        logic [31:0] tgt;
        fet_stall_i = stall; imem_gnt_i = gnt; fet_redir_i = redir; fet_redir_pc_i = rpc;
        rv = 0;
        if (mq.size() > 0) rv = (mq[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? memf(mq[0].addr) : $urandom;
        @(negedge clk_i);
        s_valid = fet_valid_o; s_pc = fet_pc_o; s_inst = fet_inst_o;
        s_req = imem_req_o; s_addr = imem_addr_o;
`ifdef FETCH_MISALIGN_EXC_EN
        s_mis = fet_misalign_o;
        chk("misalign", s_mis, halt);
`else
        s_mis = 1'b0;
`endif
        chk("valid", s_valid, occ > 0);
        if (occ > 0) begin
            chk("pc", s_pc, exp_pc);
            chk("inst", s_inst, memf(exp_pc));
        end else begin
            chk("idle_inst", s_inst, INST_NOP);
            chk("idle_pc", s_pc, 0);
        end
        chk("req", s_req, !halt && (occ + outst < DEPTH));
        if (s_req) chk("addr", s_addr, exp_req_addr);
        @(posedge clk_i); #1;
        grant = s_req & gnt;
        pop   = s_valid & !stall & !redir;
        fresh = 0;
        if (rv) begin
            m = mq.pop_front();
            fresh = (m.epoch == epoch) && !redir;
            outst--;
        end
        if (grant) begin
            d = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= d) d = mq[$].due + 1;
            mq.push_back('{s_addr, epoch, d});
            outst++;
        end
        if (redir) begin
            occ = 0;
            epoch++;
`ifdef FETCH_MISALIGN_EXC_EN
            halt = (rpc[1:0] != 2'b00);
`endif
            tgt = rpc & 32'hFFFF_FFFC;
            exp_pc = tgt;
            exp_req_addr = tgt;
        end else begin
            if (fresh) occ++;
            if (pop) begin occ--; exp_pc += 4; pops++; end
            if (grant) exp_req_addr += 4;
        end
        cyc++;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] epc, input int budget);
        int n;
        n = 0;
        do begin
            tick(0, 1, 0, 32'h0, 1);
            n++;
        end while (!s_valid && n < budget);
        chk({name, "_seen"}, s_valid, 1);
        chk({name, "_pc"}, s_pc, epc);
        chk({name, "_inst"}, s_inst, memf(epc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0;
        pops = 0;
        // Zero-wait memory, then a 10-cycle stall that fills the buffer, then release.
        tbl[0]  = '{0, 0, 32'h00, 1, 32'h00};
        tbl[1]  = '{0, 0, 32'h00, 1, 32'h04};
        tbl[2]  = '{0, 1, 32'h00, 1, 32'h08};
        tbl[3]  = '{0, 1, 32'h04, 1, 32'h0C};
        tbl[4]  = '{0, 1, 32'h08, 1, 32'h10};
        tbl[5]  = '{1, 1, 32'h0C, 1, 32'h14};
        tbl[6]  = '{1, 1, 32'h0C, 1, 32'h18};
        for (int i = 7; i <= 14; i++) tbl[i] = '{1, 1, 32'h0C, 0, 32'h00};
        tbl[15] = '{0, 1, 32'h0C, 0, 32'h00};
        tbl[16] = '{0, 1, 32'h10, 1, 32'h1C};
        tbl[17] = '{0, 1, 32'h14, 1, 32'h20};
        tbl[18] = '{0, 1, 32'h18, 1, 32'h24};
        tbl[19] = '{0, 1, 32'h1C, 1, 32'h28};
        tbl[20] = '{0, 1, 32'h20, 1, 32'h2C};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].stall, 1, 0, 32'h0, 1);
            chk("t_valid", s_valid, tbl[i].ev);
            if (tbl[i].ev) chk("t_pc", s_pc, tbl[i].epc);
            chk("t_req", s_req, tbl[i].ereq);
            if (tbl[i].ereq) chk("t_addr", s_addr, tbl[i].eaddr);
        end

        // Latency 3, two outstanding, redirect: both stale words must be dropped.
        do_reset();
        tick(0, 1, 0, 32'h0, 3);
        tick(0, 1, 0, 32'h0, 3);
        tick(0, 0, 1, 32'h100, 3);
        tick(0, 1, 0, 32'h0, 1);
        chk("A_flush_valid", s_valid, 0);
        chk("A_req", s_req, 1);
        chk("A_addr", s_addr, 32'h100);
        wait_valid("A_first", 32'h100, 20);

        // Redirect in the same cycle as a grant and an rvalid.
        do_reset();
        repeat (6) tick(0, 1, 0, 32'h0, 1);
        tick(0, 1, 1, 32'h200, 1);
        chk("B_redir_req", s_req, 1);
        tick(0, 1, 0, 32'h0, 1);
        chk("B_n1_valid", s_valid, 0);
        chk("B_n1_addr", s_addr, 32'h200);
        tick(0, 1, 0, 32'h0, 1);
        chk("B_n2_valid", s_valid, 0);
        tick(0, 1, 0, 32'h0, 1);
        chk("B_n3_valid", s_valid, 1);
        chk("B_n3_pc", s_pc, 32'h200);
        tick(0, 1, 0, 32'h0, 1);
        chk("B_n4_pc", s_pc, 32'h204);
        chk("B_n4_inst", s_inst, memf(32'h204));

        // No grant for 5 cycles, then redirect: address switches with no phantom count.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 32'h0, 1);
            chk("C_hold_addr", s_addr, 32'h0);
        end
        tick(0, 0, 1, 32'h380, 1);
        tick(0, 1, 0, 32'h0, 1);
        chk("C_req", s_req, 1);
        chk("C_addr", s_addr, 32'h380);
        wait_valid("C_first", 32'h380, 10);

`ifdef FETCH_MISALIGN_EXC_EN
        do_reset();
        repeat (3) tick(0, 1, 0, 32'h0, 1);
        tick(1, 1, 1, 32'h102, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 32'h0, 1);
            chk("E_mis", s_mis, 1);
            chk("E_req", s_req, 0);
            chk("E_inst", s_inst, INST_NOP);
        end
        tick(0, 1, 1, 32'h300, 1);
        tick(0, 1, 0, 32'h0, 1);
        chk("E_clear", s_mis, 0);
        chk("E_resume_addr", s_addr, 32'h300);
        wait_valid("E_first", 32'h300, 10);
`else
        do_reset();
        repeat (3) tick(0, 1, 0, 32'h0, 1);
        tick(1, 1, 1, 32'h102, 1);
        wait_valid("D_aligned", 32'h100, 10);
`endif

        // Randomized traffic against the stream model, with occasional resets.
        do_reset();
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 99) < 3,
                     ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0),
                     $urandom_range(1, 4));
            end
        end
        chk("rand_progress", (pops - p0) > 300, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
